// File: rtl/adder_seq_ctrl.sv
// Sequential adder controller: a single 4-bit ripple slice is reused once per
// nibble, LSB nibble first. The result is published on SUM/CARRY/OVF only when
// all nibbles are done, together with a one-cycle DONE pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last published result
//   RUN   | one nibble per cycle through the slice, carry chained via cy_reg
//   FIN   | result published, done pulses; a new start is accepted here

module Adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Four full adders chained bit by bit.
  always_comb begin : ripple
    logic c;
    c    = cin;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  // Counter reaches NIBBLES after the last nibble, so it must hold NIBBLES.
  localparam int CW = (NIBBLES < 1) ? 1 : $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cy_reg;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  res;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    slice_sum;
  logic          slice_cout;
  logic [W-1:0]  res_next;
  logic          last_nib;
  logic          ovf_next;

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        nib_a = op_a[4*i +: 4];
        nib_b = op_b[4*i +: 4];
      end
    end
  end

  Adder4bit u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cy_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Merge this cycle's slice result into the partial result vector.
  always_comb begin
    res_next = res;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        res_next[4*i +: 4] = slice_sum;
      end
    end
  end

  assign last_nib = (cnt == CW'(NIBBLES - 1));
  assign ovf_next = (op_a[W-1] == op_b[W-1]) && (res_next[W-1] != op_a[W-1]);

  // Sequencer with registered outputs; partial results stay in res until the
  // final nibble, so SUM never shows an intermediate value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cy_reg <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            cy_reg <= cin;
            cnt    <= '0;
            res    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          res    <= res_next;
          cy_reg <= slice_cout;
          cnt    <= cnt + CW'(1);
          if (last_nib) begin
            sum   <= res_next;
            carry <= slice_cout;
            ovf   <= ovf_next;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
